// File: rtl/tree_pkg.sv
// Shared definitions for the tree fan-out / reduction blocks.
//   state_t    : frame-control FSM states (FILL -> DRAIN -> DONE)
//   tree_depth : pipeline depth needed to cover n leaves (clog2, minimum 1)
package tree_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int tree_depth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tree_scatter_if.sv
// Handshake bundle for tree_scatter.
//   in_valid/in_ready  : word transfer handshake (producer -> block)
//   in_data, in_bcast  : word and "send to every leaf, close frame" flag
//   out                : packed leaves, leaf i at out[(i+1)*LEN-1:i*LEN]
//   out_valid/out_ready: full-frame handshake (block -> consumer)
// master = producer/consumer side, slave = the scatter block.
interface tree_scatter_if #(
  parameter int NUM = 4096,
  parameter int LEN = 16
);

  logic               in_valid;
  logic               in_ready;
  logic [LEN-1:0]     in_data;
  logic               in_bcast;
  logic [NUM*LEN-1:0] out;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_valid, in_data, in_bcast, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in_valid, in_data, in_bcast, out_ready,
    output in_ready, out, out_valid
  );

endinterface

// File: rtl/tree_scatter_stage.sv
// scatter_stage: one register stage of the fan-out pipeline.
// Carries {valid, data, leaf index, bcast} forward by one clock.
//   clk, rst_n          : clock, asynchronous active-low clear
//   in_*                : stage input fields
//   out_*               : registered stage output fields
module scatter_stage #(
  parameter int LEN = 16,
  parameter int IW  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [LEN-1:0] in_data,
  input  logic [IW-1:0]  in_idx,
  input  logic           in_bcast,
  output logic           out_valid,
  output logic [LEN-1:0] out_data,
  output logic [IW-1:0]  out_idx,
  output logic           out_bcast
);

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value; blocking here would collapse the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_bcast <= 1'b0;
    end else begin
      out_valid <= in_valid;
      out_data  <= in_data;
      out_idx   <= in_idx;
      out_bcast <= in_bcast;
    end
  end

endmodule

// File: rtl/tree_scatter.sv
// tree_scatter: collects a frame of NUM words (or one broadcast word) into
// NUM leaf registers through a LEVEL-deep pipeline, then presents the whole
// frame on bus.out until the consumer takes it.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : tree_scatter_if slave (in_valid/in_ready/in_data/in_bcast,
//           out/out_valid/out_ready)
module tree_scatter
  import tree_pkg::*;
#(
  parameter int NUM   = 4096,
  parameter int LEN   = 16,
  parameter int LEVEL = tree_depth(NUM)
) (
  input  logic          clk,
  input  logic          rst_n,
  tree_scatter_if.slave bus
);

  localparam int IW = $clog2(NUM);
  localparam int CW = $clog2(NUM + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            upstream_busy;

  // Pipeline taps: index 0 is the stage input, index LEVEL the final output.
  logic [LEVEL:0]  st_valid;
  logic [LEVEL:0]  st_bcast;
  logic [LEN-1:0]  st_data [LEVEL+1];
  logic [IW-1:0]   st_idx  [LEVEL+1];

  logic [LEN-1:0]  leaf [NUM];

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == DONE);
  assign accept        = bus.in_valid && (state_q == FILL);

  // cnt < NUM whenever FILL accepts, so the truncation to a leaf index is exact.
  assign st_valid[0] = accept;
  assign st_data[0]  = bus.in_data;
  assign st_idx[0]   = cnt_q[IW-1:0];
  assign st_bcast[0] = bus.in_bcast;

  for (genvar k = 0; k < LEVEL; k++) begin : g_stage
    scatter_stage #(.LEN(LEN), .IW(IW)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (st_valid[k]),
      .in_data   (st_data[k]),
      .in_idx    (st_idx[k]),
      .in_bcast  (st_bcast[k]),
      .out_valid (st_valid[k+1]),
      .out_data  (st_data[k+1]),
      .out_idx   (st_idx[k+1]),
      .out_bcast (st_bcast[k+1])
    );
  end

  // Words held in stages before the last one. Once these are empty in DRAIN,
  // the coming edge retires the final word, so DONE and out_valid line up
  // with the frame's last leaf write.
  always_comb begin
    upstream_busy = 1'b0;
    for (int k = 1; k < LEVEL; k++) upstream_busy = upstream_busy | st_valid[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (bus.in_bcast || (cnt_q == CW'(NUM - 1))) begin
            cnt_d   = CW'(NUM);
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (!upstream_busy) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  // Leaf write decode. A broadcast word hits every leaf; otherwise only the
  // leaf whose index matches.
  // NOTE: the leaves are cleared on reset because they are the visible output
  // and must read 0 during reset; a plain storage array would not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM; i++) leaf[i] <= '0;
    end else if (st_valid[LEVEL]) begin
      for (int i = 0; i < NUM; i++) begin
        if (st_bcast[LEVEL] || (st_idx[LEVEL] == IW'(i))) leaf[i] <= st_data[LEVEL];
      end
    end
  end

  for (genvar i = 0; i < NUM; i++) begin : g_out
    assign bus.out[(i+1)*LEN-1 -: LEN] = leaf[i];
  end

endmodule

// File: doc/tree_scatter.md
TREE_SCATTER -- requirements
Module: tree_scatter

Interface
REQ-001 SHALL have parameter NUM, default 4096, giving the number of leaf outputs; legal range NUM >= 2, non-power-of-two allowed.
REQ-002 SHALL have parameter LEN, default 16, giving the word width in bits.
REQ-003 SHALL have parameter LEVEL, default $clog2(NUM), giving the fan-out pipeline depth; it is not overridden.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  in_data/in_bcast carry a word.
REQ-007 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port in_data  input  LEN  word to distribute.
REQ-009 SHALL have port in_bcast  input  1  word goes to every leaf and closes the frame.
REQ-010 SHALL have port out  output  NUM*LEN  packed leaves; leaf i occupies out[(i+1)*LEN-1:i*LEN].
REQ-011 SHALL have port out_valid  output  1  full frame present on out.
REQ-012 SHALL have port out_ready  input  1  consumer takes the frame.

Function
REQ-013 SHALL accept a word on any rising edge where in_valid and in_ready are both 1; nothing else counts as a transfer.
REQ-014 SHALL use FSM states FILL, DRAIN and DONE, with FILL entered from reset.
REQ-015 SHALL drive in_ready = 1 only in FILL.
REQ-016 SHALL keep a write counter cnt (0..NUM) in FILL; each non-broadcast transfer sends in_data to leaf cnt and then increments cnt.
REQ-017 SHALL, for a broadcast transfer (in_bcast=1), tag the word for all leaves, write the same data to leaves 0..NUM-1, and force cnt to NUM; a broadcast at cnt>0 also overwrites leaves already written.
REQ-018 SHALL move FILL->DRAIN on the edge where cnt reaches NUM.
REQ-019 SHALL, in DRAIN, wait until the pipeline is empty and then move to DONE.
REQ-020 SHALL, in DONE, move DONE->FILL with cnt cleared on an edge where out_ready=1.
REQ-021 SHALL carry each accepted word through LEVEL register stages, each stage holding {valid, data, leaf index, bcast}.
REQ-022 SHALL write a word accepted on edge E into its leaf register on edge E+LEVEL.
REQ-023 SHALL let the pipeline accept one word per cycle; in_valid gaps create bubbles and do not stall or drop stages.
REQ-024 SHALL raise out_valid on the same edge that the frame's last leaf write occurs, i.e. edge E_last+LEVEL, and keep it high through DONE.
REQ-025 SHALL hold out stable while out_valid=1.
REQ-026 SHALL have leaves retain their values after DONE->FILL until overwritten; out_valid stays 0 in FILL and DRAIN.
REQ-027 SHALL never generate a leaf index >= NUM.
REQ-028 SHALL, when out_ready=1 and in_valid=1 in the same DONE cycle, accept no word; the word is accepted no earlier than the next cycle (in FILL).
REQ-029 SHALL ignore out_ready outside DONE.

Reset
REQ-030 SHALL, on rst_n=0, immediately force: state FILL, cnt 0, all pipeline valid bits 0, all leaves 0, out = 0, out_valid 0, in_ready 1 once rst_n has risen.
REQ-031 SHALL, on reset asserted mid-frame or mid-drain, discard the frame and all in-flight words; no partial frame is ever flagged valid.

Structure
REQ-032 SHALL place a shared package tree_pkg holding the state enum (FILL/DRAIN/DONE) and a clog2-based depth helper, shared with the reduction tree.
REQ-033 SHALL use one sub-module, scatter_stage, as one pipeline register stage ({valid, data, index, bcast}, async active-low clear), instantiated LEVEL times in a generate loop.
REQ-034 SHALL implement the leaf write decode in tree_scatter; no per-leaf sub-module.

Verification (NUM=4, LEN=16, LEVEL=2 unless stated)
REQ-035 SHALL cover: back-to-back words 0x0001,0x0002,0x0003,0x0004 with out_ready=0 -> out_valid rises 2 edges after 4th accept, out = 0x0004_0003_0002_0001, in_ready=0 until out_ready pulse.
REQ-036 SHALL cover: single bcast word 0xBEEF at cnt=0 -> out = {4{0xBEEF}} and out_valid after 2 edges.
REQ-037 SHALL cover: words 0x0011,0x0022 then bcast 0x00AA -> all leaves 0x00AA and frame closed.
REQ-038 SHALL cover: in_valid toggling every other cycle -> same frame contents as back-to-back, out_valid 2 edges after last accept.
REQ-039 SHALL cover: rst_n low after 2 accepts and mid-pipeline -> out=0, out_valid=0; the next 4 words form a fresh frame.
REQ-040 SHALL cover: NUM=5 (LEVEL=3), words 1..5 -> leaves 0..4 = 1..5, out_valid 3 edges after 5th accept.
